button_bank: RTL and testbench
==============================

// Module: button_bank
// PURPOSE
//  N-channel push-button conditioner for board UI. Per channel: 2-FF synchroniser,
//  stability-counter debounce, press/release strobes, long-press strobe and optional
//  auto-repeat. Sits between raw key pins and the test-control FSMs.
//  All outputs are registered and in the clk domain.
// PARAMETERS
//  N_CH           4           number of independent channels
//  ACTIVE_LOW     1           1: pin low = pressed (inverted before the synchroniser)
//  STABLE_CYCLES  1_000_000   cycles the input must stay unchanged (20 ms @ 50 MHz); >=2
//  LONG_CYCLES    50_000_000  held cycles after debounced press before long_p (1 s); >=2
//  REPEAT_CYCLES  10_000_000  auto-repeat period after long_p; 0 disables repeat
// PORTS
//  clk         in   1     system clock
//  rst         in   1     reset, asynchronous, active-high
//  key_in      in   N_CH  raw asynchronous button pins
//  key_state   out  N_CH  debounced level, 1 = pressed
//  press_p     out  N_CH  1-cycle strobe on debounced 0->1
//  release_p   out  N_CH  1-cycle strobe on debounced 1->0
//  long_p      out  N_CH  1-cycle strobe when held LONG_CYCLES
//  repeat_p    out  N_CH  1-cycle strobe every REPEAT_CYCLES after long_p
//  long_held   out  N_CH  level: long_p has fired, key still pressed
// BEHAVIOUR
//  - One clock; reset is asynchronous and active-high. rst clears every register: all
//    outputs 0, sync flops 0, counters 0. Released state is 0 after reset regardless of
//    ACTIVE_LOW; a key held through reset yields press_p one debounce latency after rst drops.
//  - Sync: lvl = key_in ^ ACTIVE_LOW; s0<=lvl, s1<=s0, s2<=s1 (s0/s1 = metastability pair).
//  - Debounce cnt (width clog2(STABLE_CYCLES+1)): s1!=s2 -> cnt<=0; else cnt<=cnt+1,
//    saturating at STABLE_CYCLES (never wraps; fixes 20-bit wrap re-sample).
//  - Commit: on the edge where s1==s2 and cnt==STABLE_CYCLES-1: key_state<=s2; if s2 differs
//    from key_state, press_p or release_p <=1 on that edge, else 0. Strobes last exactly 1 cycle.
//  - Latency: clean step on key_in -> key_state changes STABLE_CYCLES+3 edges later.
//    Any toggle restarts the window; glitches shorter than STABLE_CYCLES never reach key_state.
//  - Hold counter hcnt (width clog2(max(LONG,REPEAT)+1)), evaluated on pre-edge key_state:
//    key_state==0 -> hcnt<=0, long_held<=0, no strobes.
//    key_state==1, long_held==0: hcnt++; at hcnt==LONG_CYCLES-1 -> long_p<=1, long_held<=1,
//    hcnt<=0. So long_p fires LONG_CYCLES cycles after press_p.
//    key_state==1, long_held==1, REPEAT_CYCLES>0: hcnt++; at hcnt==REPEAT_CYCLES-1 ->
//    repeat_p<=1, hcnt<=0. REPEAT_CYCLES==0: hcnt holds, repeat_p stays 0.
//  - Release commit on the same edge a long/repeat strobe is due: strobe still fires
//    (pre-edge state), counters clear next cycle; release_p and long_p may coincide.
//  - Channels fully independent; simultaneous events on several channels all reported.
//  - rst mid-operation: strobes in flight dropped, no release_p generated.
// STRUCTURE
//  - Shared package/header: clog2 function, default timing constants (20 ms / 1 s / 200 ms
//    at 50 MHz) so other UI blocks use identical timing.
//  - Sub-module button_chan: one channel (sync, debounce, hold logic), same parameters
//    minus N_CH; button_bank is a generate loop of N_CH instances plus port packing.
// TESTING  (N_CH=4, STABLE_CYCLES=8, LONG_CYCLES=32, REPEAT_CYCLES=10, ACTIVE_LOW=1)
//  1 rst=1 with key_in=4'b0000 (all pressed) -> all outputs 0; rst falls -> press_p[3:0]=1111
//    for one cycle 11 edges later, key_state=1111.
//  2 key_in[0] 1->0 clean step -> key_state[0] rises on edge 11, press_p[0] 1 cycle; release
//    step -> release_p[0] 11 edges later; other channels quiet.
//  3 key_in[1] toggles every 5 cycles for 40 cycles then held low -> exactly one press_p[1],
//    11 edges after last toggle; no release_p[1].
//  4 key_in[2] held low 100 cycles past press_p -> long_p at +32, long_held=1, repeat_p at
//    +42,+52,+62...; release -> long_held clears, no further repeat_p. Rerun REPEAT_CYCLES=0:
//    no repeat_p.
//  5 3-cycle glitch on key_in[3] while pressed -> no strobes; hold counter unaffected.
//  6 rst pulse mid-hold on ch2 (after long_p) -> outputs 0 immediately, no release_p; key still
//    held -> fresh press_p 11 edges after rst falls, long_p 32 cycles later.

Source files
------------

// File: rtl/button_bank_pkg.sv
// Shared UI timing constants and helpers for push-button conditioning.
package button_bank_pkg;

  // Default board timing at 50 MHz: 20 ms debounce, 1 s long press, 200 ms repeat.
  localparam int unsigned CLK_HZ            = 50_000_000;
  localparam int unsigned DEF_STABLE_CYCLES = 1_000_000;
  localparam int unsigned DEF_LONG_CYCLES   = 50_000_000;
  localparam int unsigned DEF_REPEAT_CYCLES = 10_000_000;

  // Per-channel registered outputs, packed together so the bank can unpack them.
  typedef struct packed {
    logic level;  // debounced state, 1 = pressed
    logic press;  // debounced 0->1 strobe
    logic rel;    // debounced 1->0 strobe
    logic lng;    // long-press strobe
    logic rpt;    // auto-repeat strobe
    logic held;   // long press reached and key still down
  } btn_evt_t;

  // Bits needed to hold values 0..v-1.
  function automatic int unsigned clog2(input longint unsigned v);
    int unsigned     r;
    longint unsigned x;
    r = 0;
    x = 1;
    while (x < v) begin
      x = x << 1;
      r++;
    end
    return r;
  endfunction

  function automatic longint unsigned max_u(input longint unsigned a,
                                            input longint unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/button_bank_chan.sv
// One push-button channel: 2-FF synchroniser, stability debounce,
// press/release strobes, long-press strobe and optional auto-repeat.
module button_chan
  import button_bank_pkg::*;
#(
  parameter bit          ACTIVE_LOW    = 1'b1,
  parameter int unsigned STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter int unsigned LONG_CYCLES   = DEF_LONG_CYCLES,
  parameter int unsigned REPEAT_CYCLES = DEF_REPEAT_CYCLES
) (
  input  logic     clk_i,
  input  logic     rst_i,
  input  logic     key_i,
  output btn_evt_t evt_o
);

  localparam int unsigned CW = clog2(longint'(STABLE_CYCLES) + 1);
  localparam int unsigned HW = clog2(max_u(LONG_CYCLES, REPEAT_CYCLES) + 1);

  // sync_q[0] = s0, sync_q[1] = s1, sync_q[2] = s2
  logic [2:0]    sync_q,  sync_d;
  logic [CW-1:0] cnt_q,   cnt_d;
  logic          state_q, state_d;
  logic          press_q, press_d;
  logic          rel_q,   rel_d;
  logic [HW-1:0] hcnt_q,  hcnt_d;
  logic          long_q,  long_d;
  logic          rpt_q,   rpt_d;
  logic          held_q,  held_d;
  logic          commit;

  // Next-state: synchroniser shift, saturating stability count, commit, hold timing.
  always_comb begin
    sync_d  = {sync_q[1:0], key_i ^ ACTIVE_LOW};
    cnt_d   = cnt_q;
    state_d = state_q;
    press_d = 1'b0;
    rel_d   = 1'b0;
    hcnt_d  = hcnt_q;
    long_d  = 1'b0;
    rpt_d   = 1'b0;
    held_d  = held_q;

    if (sync_q[1] != sync_q[2]) begin
      cnt_d = '0;
    end else if (cnt_q != CW'(STABLE_CYCLES)) begin
      cnt_d = cnt_q + 1'b1;
    end

    commit = (sync_q[1] == sync_q[2]) && (cnt_q == CW'(STABLE_CYCLES - 1));
    if (commit) begin
      state_d = sync_q[2];
      press_d = sync_q[2] & ~state_q;
      rel_d   = ~sync_q[2] & state_q;
    end

    // Hold timing looks at the pre-edge debounced level, so a strobe due on the
    // same edge as a release commit still fires; counters clear a cycle later.
    if (!state_q) begin
      hcnt_d = '0;
      held_d = 1'b0;
    end else if (!held_q) begin
      if (hcnt_q == HW'(LONG_CYCLES - 1)) begin
        long_d = 1'b1;
        held_d = 1'b1;
        hcnt_d = '0;
      end else begin
        hcnt_d = hcnt_q + 1'b1;
      end
    end else if (REPEAT_CYCLES != 0) begin
      if (hcnt_q == HW'(REPEAT_CYCLES - 1)) begin
        rpt_d  = 1'b1;
        hcnt_d = '0;
      end else begin
        hcnt_d = hcnt_q + 1'b1;
      end
    end
  end

  // State registers; reset drops any strobe in flight.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q  <= '0;
      cnt_q   <= '0;
      state_q <= 1'b0;
      press_q <= 1'b0;
      rel_q   <= 1'b0;
      hcnt_q  <= '0;
      long_q  <= 1'b0;
      rpt_q   <= 1'b0;
      held_q  <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      cnt_q   <= cnt_d;
      state_q <= state_d;
      press_q <= press_d;
      rel_q   <= rel_d;
      hcnt_q  <= hcnt_d;
      long_q  <= long_d;
      rpt_q   <= rpt_d;
      held_q  <= held_d;
    end
  end

  assign evt_o.level = state_q;
  assign evt_o.press = press_q;
  assign evt_o.rel   = rel_q;
  assign evt_o.lng   = long_q;
  assign evt_o.rpt   = rpt_q;
  assign evt_o.held  = held_q;

endmodule

// File: rtl/button_bank.sv
// N-channel push-button conditioner: one independent button_chan per key pin.
module button_bank
  import button_bank_pkg::*;
#(
  parameter int unsigned N_CH          = 4,
  parameter bit          ACTIVE_LOW    = 1'b1,
  parameter int unsigned STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter int unsigned LONG_CYCLES   = DEF_LONG_CYCLES,
  parameter int unsigned REPEAT_CYCLES = DEF_REPEAT_CYCLES
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] key_in,
  output logic [N_CH-1:0] key_state,
  output logic [N_CH-1:0] press_p,
  output logic [N_CH-1:0] release_p,
  output logic [N_CH-1:0] long_p,
  output logic [N_CH-1:0] repeat_p,
  output logic [N_CH-1:0] long_held
);

  btn_evt_t evt [N_CH];

  for (genvar g = 0; g < N_CH; g++) begin : g_chan
    button_chan #(
      .ACTIVE_LOW    (ACTIVE_LOW),
      .STABLE_CYCLES (STABLE_CYCLES),
      .LONG_CYCLES   (LONG_CYCLES),
      .REPEAT_CYCLES (REPEAT_CYCLES)
    ) u_chan (
      .clk_i (clk),
      .rst_i (rst),
      .key_i (key_in[g]),
      .evt_o (evt[g])
    );

    assign key_state[g] = evt[g].level;
    assign press_p[g]   = evt[g].press;
    assign release_p[g] = evt[g].rel;
    assign long_p[g]    = evt[g].lng;
    assign repeat_p[g]  = evt[g].rpt;
    assign long_held[g] = evt[g].held;
  end

endmodule

// File: tb/tb_button_bank.sv
// Self-checking bench for button_bank: two instances (repeat on / repeat off)
// compared every cycle against an event-level reference model.
module tb_button_bank;

  localparam int ST = 8;
  localparam int LG = 32;
  localparam int RP = 10;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] key_in;
  logic [3:0] ks_a, pr_a, rl_a, lg_a, rp_a, hd_a;
  logic [3:0] ks_b, pr_b, rl_b, lg_b, rp_b, hd_b;
  logic [23:0] obs_a, obs_b, exp_a, exp_b;

  always #5 clk = ~clk;

  button_bank #(.N_CH(4), .ACTIVE_LOW(1'b1), .STABLE_CYCLES(ST),
                .LONG_CYCLES(LG), .REPEAT_CYCLES(RP)) dut_a (
    .clk(clk), .rst(rst), .key_in(key_in), .key_state(ks_a), .press_p(pr_a),
    .release_p(rl_a), .long_p(lg_a), .repeat_p(rp_a), .long_held(hd_a));

  button_bank #(.N_CH(4), .ACTIVE_LOW(1'b1), .STABLE_CYCLES(ST),
                .LONG_CYCLES(LG), .REPEAT_CYCLES(0)) dut_b (
    .clk(clk), .rst(rst), .key_in(key_in), .key_state(ks_b), .press_p(pr_b),
    .release_p(rl_b), .long_p(lg_b), .repeat_p(rp_b), .long_held(hd_b));

  assign obs_a = {ks_a, pr_a, rl_a, lg_a, rp_a, hd_a};
  assign obs_b = {ks_b, pr_b, rl_b, lg_b, rp_b, hd_b};

  int unsigned checks = 0;
  int unsigned passes = 0;

  // Reference model: pressed level seen two edges late; a level that has been
  // seen unchanged for ST+1 consecutive edges becomes the debounced state.
  // Hold events are timed from the edge of the press commit.
  logic [3:0] a0, a1, pv, mks, m_press, m_rel, m_long, m_rep, m_held;
  int         run [4];
  longint     pt  [4];
  longint     cyc = 0;

  function automatic void model_reset();
    a0 = '0; a1 = '0; pv = '0; mks = '0;
    m_press = '0; m_rel = '0; m_long = '0; m_rep = '0; m_held = '0;
    for (int c = 0; c < 4; c++) begin
      run[c] = 1;
      pt[c]  = 0;
    end
    exp_a = '0;
    exp_b = '0;
  endfunction

  function automatic void model_edge(input logic [3:0] k);
    logic   v, ks_pre;
    longint dt;
    cyc++;
    for (int c = 0; c < 4; c++) begin
      v     = a1[c];
      a1[c] = a0[c];
      a0[c] = ~k[c];
      if (v == pv[c]) begin
        if (run[c] < ST + 2) run[c]++;
      end else begin
        run[c] = 1;
      end
      pv[c]      = v;
      ks_pre     = mks[c];
      dt         = cyc - pt[c];
      m_long[c]  = ks_pre && (dt == LG);
      m_rep[c]   = ks_pre && (dt > LG) && (((dt - LG) % RP) == 0);
      m_held[c]  = ks_pre && (dt >= LG);
      m_press[c] = 1'b0;
      m_rel[c]   = 1'b0;
      if (run[c] == ST + 1) begin
        m_press[c] = v & ~ks_pre;
        m_rel[c]   = ~v & ks_pre;
        mks[c]     = v;
        if (v && !ks_pre) pt[c] = cyc;
      end
    end
    exp_a = {mks, m_press, m_rel, m_long, m_rep, m_held};
    exp_b = {mks, m_press, m_rel, m_long, 4'b0000, m_held};
  endfunction

  task automatic tick();
    logic [3:0] k;
    logic       r;
    k = key_in;
    r = rst;
    @(posedge clk);
    #1;
    if (r) model_reset();
    else   model_edge(k);
  endtask

  task automatic test_reset();
    int pe, np;
    rst = 1'b1;
    key_in = 4'b0000;
    model_reset();
    repeat (3) tick();
    checks++;
    if (obs_a !== 24'h0 || obs_b !== 24'h0)
      $display("FAIL reset_outputs got_a=%h got_b=%h exp=0", obs_a, obs_b);
    else passes++;
    rst = 1'b0;
    pe = -1; np = 0;
    for (int i = 1; i <= 40; i++) begin
      tick();
      checks++;
      if (obs_a !== exp_a) $display("FAIL reset_seq_a cyc=%0d got=%h exp=%h", cyc, obs_a, exp_a);
      else passes++;
      checks++;
      if (obs_b !== exp_b) $display("FAIL reset_seq_b cyc=%0d got=%h exp=%h", cyc, obs_b, exp_b);
      else passes++;
      if (pr_a == 4'hF) begin
        np++;
        if (pe < 0) pe = i;
      end
    end
    checks++;
    if (pe !== 11) $display("FAIL reset_press_edge got=%0d exp=11", pe); else passes++;
    checks++;
    if (np !== 1) $display("FAIL reset_press_width got=%0d exp=1", np); else passes++;
    checks++;
    if (ks_a !== 4'hF) $display("FAIL reset_key_state got=%h exp=f", ks_a); else passes++;
  endtask

  task automatic test_clean_step();
    int pe, re, other;
    key_in = 4'hF;
    for (int i = 0; i < 30; i++) begin
      tick();
      checks++;
      if (obs_a !== exp_a) $display("FAIL settle_a cyc=%0d got=%h exp=%h", cyc, obs_a, exp_a);
      else passes++;
    end
    key_in[0] = 1'b0;
    pe = -1; re = -1; other = 0;
    for (int i = 1; i <= 40; i++) begin
      if (i == 21) key_in[0] = 1'b1;
      tick();
      checks++;
      if (obs_a !== exp_a) $display("FAIL step_a cyc=%0d got=%h exp=%h", cyc, obs_a, exp_a);
      else passes++;
      checks++;
      if (obs_b !== exp_b) $display("FAIL step_b cyc=%0d got=%h exp=%h", cyc, obs_b, exp_b);
      else passes++;
      if (pr_a[0] && pe < 0) pe = i;
      if (rl_a[0] && re < 0) re = i - 20;
      other |= int'(|{pr_a[3:1], rl_a[3:1], lg_a[3:1], rp_a[3:1]});
    end
    checks++;
    if (pe !== 11) $display("FAIL step_press_edge got=%0d exp=11", pe); else passes++;
    checks++;
    if (re !== 11) $display("FAIL step_release_edge got=%0d exp=11", re); else passes++;
    checks++;
    if (other !== 0) $display("FAIL step_others_quiet got=%0d exp=0", other); else passes++;
  endtask

  task automatic test_bounce();
    int pe, np, nr;
    key_in = 4'hF;
    np = 0; nr = 0; pe = -1;
    for (int i = 0; i < 70; i++) begin
      if (i < 40 && (i % 5) == 0) key_in[1] = ~key_in[1];
      if (i == 40) key_in[1] = 1'b0;
      tick();
      checks++;
      if (obs_a !== exp_a) $display("FAIL bounce_a cyc=%0d got=%h exp=%h", cyc, obs_a, exp_a);
      else passes++;
      if (pr_a[1]) begin
        np++;
        pe = i - 39;
      end
      if (rl_a[1]) nr++;
    end
    checks++;
    if (np !== 1) $display("FAIL bounce_press_count got=%0d exp=1", np); else passes++;
    checks++;
    if (pe !== 11) $display("FAIL bounce_press_edge got=%0d exp=11", pe); else passes++;
    checks++;
    if (nr !== 0) $display("FAIL bounce_release_count got=%0d exp=0", nr); else passes++;
  endtask

  task automatic test_long_repeat();
    int pe, le, fr, nra, nrb;
    key_in = 4'hF;
    for (int i = 0; i < 20; i++) tick();
    key_in[2] = 1'b0;
    pe = -1; le = -1; fr = -1; nra = 0; nrb = 0;
    for (int e = 1; e <= 150; e++) begin
      if (e == 112) key_in[2] = 1'b1;
      tick();
      checks++;
      if (obs_a !== exp_a) $display("FAIL long_a cyc=%0d got=%h exp=%h", cyc, obs_a, exp_a);
      else passes++;
      checks++;
      if (obs_b !== exp_b) $display("FAIL long_b cyc=%0d got=%h exp=%h", cyc, obs_b, exp_b);
      else passes++;
      if (pr_a[2] && pe < 0) pe = e;
      if (lg_a[2] && le < 0) le = e;
      if (rp_a[2]) begin
        nra++;
        if (fr < 0) fr = e;
      end
      if (rp_b[2]) nrb++;
      if (e == 111) begin
        checks++;
        if (hd_a[2] !== 1'b1 || hd_b[2] !== 1'b1)
          $display("FAIL long_held_level got_a=%b got_b=%b exp=1", hd_a[2], hd_b[2]);
        else passes++;
      end
    end
    checks++;
    if (le - pe !== 32) $display("FAIL long_offset got=%0d exp=32", le - pe); else passes++;
    checks++;
    if (fr - pe !== 42) $display("FAIL repeat_first got=%0d exp=42", fr - pe); else passes++;
    checks++;
    if (nra !== 7) $display("FAIL repeat_count got=%0d exp=7", nra); else passes++;
    checks++;
    if (nrb !== 0) $display("FAIL repeat_disabled got=%0d exp=0", nrb); else passes++;
    checks++;
    if (hd_a[2] !== 1'b0) $display("FAIL long_held_clear got=%b exp=0", hd_a[2]); else passes++;
  endtask

  task automatic test_glitch();
    int pe, le, np, nr, g;
    key_in = 4'hF;
    for (int i = 0; i < 20; i++) tick();
    g = int'($urandom_range(3, 15));
    key_in[3] = 1'b0;
    pe = -1; le = -1; np = 0; nr = 0;
    for (int e = 1; e <= 60; e++) begin
      if (pe > 0 && e == pe + g)     key_in[3] = 1'b1;
      if (pe > 0 && e == pe + g + 3) key_in[3] = 1'b0;
      tick();
      checks++;
      if (obs_a !== exp_a) $display("FAIL glitch_a cyc=%0d got=%h exp=%h", cyc, obs_a, exp_a);
      else passes++;
      if (pr_a[3]) begin
        np++;
        if (pe < 0) pe = e;
      end
      if (rl_a[3]) nr++;
      if (lg_a[3] && le < 0) le = e;
    end
    checks++;
    if (np !== 1 || nr !== 0) $display("FAIL glitch_strobes got_press=%0d got_rel=%0d exp=1/0", np, nr);
    else passes++;
    checks++;
    if (le - pe !== 32) $display("FAIL glitch_long_offset got=%0d exp=32", le - pe); else passes++;
    key_in = 4'hF;
    for (int i = 0; i < 20; i++) tick();
  endtask

  task automatic test_rst_mid_hold();
    int pe, le, nr;
    key_in = 4'hF;
    key_in[2] = 1'b0;
    nr = 0;
    for (int e = 1; e <= 50; e++) begin
      tick();
      if (rl_a[2]) nr++;
    end
    checks++;
    if (hd_a[2] !== 1'b1) $display("FAIL pre_rst_held got=%b exp=1", hd_a[2]); else passes++;
    rst = 1'b1;
    model_reset();
    #1;
    checks++;
    if (obs_a !== 24'h0 || obs_b !== 24'h0)
      $display("FAIL mid_rst_outputs got_a=%h got_b=%h exp=0", obs_a, obs_b);
    else passes++;
    repeat (3) tick();
    rst = 1'b0;
    pe = -1; le = -1;
    for (int e = 1; e <= 50; e++) begin
      tick();
      checks++;
      if (obs_a !== exp_a) $display("FAIL rst_hold_a cyc=%0d got=%h exp=%h", cyc, obs_a, exp_a);
      else passes++;
      if (pr_a[2] && pe < 0) pe = e;
      if (lg_a[2] && le < 0) le = e;
      if (rl_a[2]) nr++;
    end
    checks++;
    if (pe !== 11) $display("FAIL rst_press_edge got=%0d exp=11", pe); else passes++;
    checks++;
    if (le - pe !== 32) $display("FAIL rst_long_offset got=%0d exp=32", le - pe); else passes++;
    checks++;
    if (nr !== 0) $display("FAIL rst_no_release got=%0d exp=0", nr); else passes++;
  endtask

  task automatic test_random();
    int unsigned lim;
    key_in = 4'hF;
    for (int i = 0; i < 1500; i++) begin
      lim = (i < 600) ? 10 : 55;
      for (int c = 0; c < 4; c++)
        if ($urandom_range(0, lim) == 0) key_in[c] = ~key_in[c];
      if (i == 1000) begin
        rst = 1'b1;
        model_reset();
      end
      if (i == 1003) rst = 1'b0;
      tick();
      checks++;
      if (obs_a !== exp_a) $display("FAIL random_a cyc=%0d got=%h exp=%h", cyc, obs_a, exp_a);
      else passes++;
      checks++;
      if (obs_b !== exp_b) $display("FAIL random_b cyc=%0d got=%h exp=%h", cyc, obs_b, exp_b);
      else passes++;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_clean_step();
    test_bounce();
    test_long_repeat();
    test_glitch();
    test_rst_mid_hold();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
